// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / control hazard unit.
package hazard_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      LU_STALL = 1'b1
   } hazState_t;

   localparam int unsigned LOAD_STALL_MIN = 1;
   localparam int unsigned LOAD_STALL_MAX = 7;

   // Width needed to hold 0..loadStall in the bubble down-counter.
   function automatic int unsigned cntWidth(input int unsigned loadStall);
      return (loadStall < 1) ? 1 : $clog2(loadStall + 1);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Combinational load-use match: a load in EX writes a register the ID
// instruction actually reads. Register 0 never matches.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic              memRead,
   input  logic [REG_AW-1:0] exRt,
   input  logic [REG_AW-1:0] idRs,
   input  logic [REG_AW-1:0] idRt,
   input  logic              rsUsed,
   input  logic              rtUsed,
   output logic              hit
);

   logic rsHit;
   logic rtHit;

   always_comb begin
      rsHit = rsUsed && (idRs == exRt);
      rtHit = rtUsed && (idRt == exRt);
      hit   = memRead && (exRt != '0) && (rsHit || rtHit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, memory-busy freeze and branch flush arbitration.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LOAD_STALL = 1,
   parameter int unsigned PERF_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_ex_memread_i,
   input  logic [REG_AW-1:0] id_ex_rt_i,
   input  logic [REG_AW-1:0] if_id_rs_i,
   input  logic [REG_AW-1:0] if_id_rt_i,
   input  logic              if_id_rs_used_i,
   input  logic              if_id_rt_used_i,
   input  logic              mem_busy_i,
   input  logic              branch_taken_i,
   output logic              pc_write_o,
   output logic              if_id_write_o,
   output logic              id_ex_bubble_o,
   output logic              if_id_flush_o,
   output logic              freeze_o,
   output logic              stall_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cycles_o,
   output logic [PERF_W-1:0] flush_count_o
`endif
);

   localparam int unsigned CNT_W = cntWidth(LOAD_STALL);

   if (LOAD_STALL < LOAD_STALL_MIN || LOAD_STALL > LOAD_STALL_MAX) begin : gBadLoadStall
      $error("hazard_ctrl: LOAD_STALL out of range 1..7");
   end
   if (PERF_W < 1) begin : gBadPerfW
      $error("hazard_ctrl: PERF_W must be at least 1");
   end

   hazState_t        state;
   hazState_t        nextState;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nextCnt;
   logic             hit;
   logic             freeze;

   hazard_match #(
      .REG_AW(REG_AW)
   ) uMatch (
      .memRead(id_ex_memread_i),
      .exRt   (id_ex_rt_i),
      .idRs   (if_id_rs_i),
      .idRt   (if_id_rt_i),
      .rsUsed (if_id_rs_used_i),
      .rtUsed (if_id_rt_used_i),
      .hit    (hit)
   );

   assign freeze = mem_busy_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   always_comb begin
      nextState      = state;
      nextCnt        = cnt;
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      id_ex_bubble_o = 1'b0;
      freeze_o       = 1'b0;
      stall_o        = 1'b0;

      if (freeze) begin
         // Everything holds; only the status reflects an in-flight stall.
         freeze_o      = 1'b1;
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         stall_o       = (state == LU_STALL);
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  stall_o        = 1'b1;
                  pc_write_o     = 1'b0;
                  if_id_write_o  = 1'b0;
                  id_ex_bubble_o = 1'b1;
                  if (LOAD_STALL > 1) begin
                     nextState = LU_STALL;
                     nextCnt   = CNT_W'(LOAD_STALL - 1);
                  end
               end
            end
            LU_STALL: begin
               stall_o        = 1'b1;
               pc_write_o     = 1'b0;
               if_id_write_o  = 1'b0;
               id_ex_bubble_o = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  nextState = IDLE;
                  nextCnt   = '0;
               end else begin
                  nextCnt = cnt - CNT_W'(1);
               end
            end
            default: begin
               nextState = IDLE;
               nextCnt   = '0;
            end
         endcase
      end
   end

   assign if_id_flush_o = branch_taken_i && !freeze && !stall_o;

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stallCycles;
   logic [PERF_W-1:0] flushCount;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         if (stall_o && !freeze && (stallCycles != '1)) begin
            stallCycles <= stallCycles + PERF_W'(1);
         end
         if (if_id_flush_o && (flushCount != '1)) begin
            flushCount <= flushCount + PERF_W'(1);
         end
      end
   end

   assign stall_cycles_o = stallCycles;
   assign flush_count_o  = flushCount;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: LOAD_STALL=1 instance driven from a vector table,
// LOAD_STALL=3 instance driven by multi-cycle sequences.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       memRead;
      logic [4:0] exRt;
      logic [4:0] idRs;
      logic [4:0] idRt;
      logic       rsUsed;
      logic       rtUsed;
      logic       busy;
      logic       branch;
   } stim_t;

   typedef struct {
      stim_t      in;
      logic [5:0] exp;
   } vec_t;

   // Expected output bundles: {pc, ifid, bubble, flush, freeze, stall}
   localparam logic [5:0] NORM  = 6'b110000;
   localparam logic [5:0] STALL = 6'b001001;
   localparam logic [5:0] FLUSH = 6'b110100;
   localparam logic [5:0] FRZ   = 6'b000010;
   localparam logic [5:0] FRZST = 6'b000011;

   logic  clk = 1'b0;
   logic  rst_n;
   stim_t s1;
   stim_t s3;
   logic  pc1, ifid1, bub1, fl1, frz1, st1;
   logic  pc3, ifid3, bub3, fl3, frz3, st3;
   int    checks = 0;
   int    errors = 0;
   vec_t  vecs[12];

`ifdef HAZARD_PERF_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .PERF_W(32)) dut1 (
      .clk_i(clk), .rst_i(rst_n),
      .id_ex_memread_i(s1.memRead), .id_ex_rt_i(s1.exRt),
      .if_id_rs_i(s1.idRs), .if_id_rt_i(s1.idRt),
      .if_id_rs_used_i(s1.rsUsed), .if_id_rt_used_i(s1.rtUsed),
      .mem_busy_i(s1.busy), .branch_taken_i(s1.branch),
      .pc_write_o(pc1), .if_id_write_o(ifid1), .id_ex_bubble_o(bub1),
      .if_id_flush_o(fl1), .freeze_o(frz1), .stall_o(st1)
`ifdef HAZARD_PERF_EN
      , .stall_cycles_o(sc1), .flush_count_o(fc1)
`endif
   );

   hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .PERF_W(32)) dut3 (
      .clk_i(clk), .rst_i(rst_n),
      .id_ex_memread_i(s3.memRead), .id_ex_rt_i(s3.exRt),
      .if_id_rs_i(s3.idRs), .if_id_rt_i(s3.idRt),
      .if_id_rs_used_i(s3.rsUsed), .if_id_rt_used_i(s3.rtUsed),
      .mem_busy_i(s3.busy), .branch_taken_i(s3.branch),
      .pc_write_o(pc3), .if_id_write_o(ifid3), .id_ex_bubble_o(bub3),
      .if_id_flush_o(fl3), .freeze_o(frz3), .stall_o(st3)
`ifdef HAZARD_PERF_EN
      , .stall_cycles_o(sc3), .flush_count_o(fc3)
`endif
   );

   function automatic stim_t mk(input logic mr, input logic [4:0] exRt,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic rsU, input logic rtU,
                                input logic busy, input logic br);
      stim_t s;
      s.memRead = mr; s.exRt = exRt; s.idRs = rs; s.idRt = rt;
      s.rsUsed = rsU; s.rtUsed = rtU; s.busy = busy; s.branch = br;
      return s;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc1(input stim_t s, input logic [5:0] exp, input string nm);
      s1 = s;
      #2;
      check(nm, {26'd0, pc1, ifid1, bub1, fl1, frz1, st1}, {26'd0, exp});
      @(posedge clk); #1;
   endtask

   task automatic cyc3(input stim_t s, input logic [5:0] exp, input string nm);
      s3 = s;
      #2;
      check(nm, {26'd0, pc3, ifid3, bub3, fl3, frz3, st3}, {26'd0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      stim_t idle, haz, hazBusy, hazBr, br, busyIdle;
      idle     = mk(0, 0, 0, 0, 0, 0, 0, 0);
      haz      = mk(1, 5, 0, 5, 0, 1, 0, 0);
      hazBusy  = mk(1, 5, 0, 5, 0, 1, 1, 0);
      hazBr    = mk(1, 5, 0, 5, 0, 1, 0, 1);
      br       = mk(0, 0, 0, 0, 0, 0, 0, 1);
      busyIdle = mk(0, 0, 0, 0, 0, 0, 1, 0);

      vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), NORM};
      vecs[1]  = '{mk(1, 8, 8, 0, 1, 0, 0, 0), STALL};
      vecs[2]  = '{mk(0, 8, 8, 0, 1, 0, 0, 0), NORM};
      vecs[3]  = '{mk(1, 0, 0, 0, 1, 1, 0, 0), NORM};
      vecs[4]  = '{mk(1, 9, 0, 9, 0, 0, 0, 0), NORM};
      vecs[5]  = '{mk(1, 9, 0, 9, 0, 1, 0, 0), STALL};
      vecs[6]  = '{mk(1, 9, 9, 3, 0, 1, 0, 0), NORM};
      vecs[7]  = '{mk(0, 0, 4, 6, 1, 1, 0, 1), FLUSH};
      vecs[8]  = '{mk(1, 8, 8, 0, 1, 0, 0, 1), STALL};
      vecs[9]  = '{mk(1, 8, 8, 0, 1, 0, 1, 0), FRZ};
      vecs[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), FRZ};
      vecs[11] = '{mk(1, 17, 17, 17, 1, 1, 0, 0), STALL};

      rst_n = 1'b0;
      s1 = idle;
      s3 = idle;
      #2;
      check("reset_dut1", {26'd0, pc1, ifid1, bub1, fl1, frz1, st1}, {26'd0, NORM});
      check("reset_dut3", {26'd0, pc3, ifid3, bub3, fl3, frz3, st3}, {26'd0, NORM});
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         cyc1(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
      end
      cyc1(idle, NORM, "vec_after");

      // Three-bubble stall from a single-cycle hazard on rt=5
      cyc3(haz,  STALL, "ls3_c0");
      cyc3(idle, STALL, "ls3_c1");
      cyc3(idle, STALL, "ls3_c2");
      cyc3(idle, NORM,  "ls3_c3");
      cyc3(idle, NORM,  "ls3_c4");

      // Two-cycle freeze landing on the second stall cycle
      cyc3(haz,      STALL, "frz_c0");
      cyc3(busyIdle, FRZST, "frz_c1");
      cyc3(busyIdle, FRZST, "frz_c2");
      cyc3(idle,     STALL, "frz_c3");
      cyc3(idle,     STALL, "frz_c4");
      cyc3(idle,     NORM,  "frz_c5");

      // Freeze and hazard together in IDLE: hazard re-evaluated afterwards
      cyc3(hazBusy, FRZ,   "fh_c0");
      cyc3(haz,     STALL, "fh_c1");
      cyc3(idle,    STALL, "fh_c2");
      cyc3(idle,    STALL, "fh_c3");
      cyc3(idle,    NORM,  "fh_c4");

      // Branch ignored while stalled, honoured once back in IDLE
      cyc3(hazBr, STALL, "br_c0");
      cyc3(br,    STALL, "br_c1");
      cyc3(br,    STALL, "br_c2");
      cyc3(br,    FLUSH, "br_c3");
      cyc3(idle,  NORM,  "br_c4");

      // Asynchronous reset with cnt=2 in LU_STALL
      cyc3(haz, STALL, "rst_c0");
      s3 = idle;
      #1;
      check("rst_install", {26'd0, pc3, ifid3, bub3, fl3, frz3, st3}, {26'd0, STALL});
      rst_n = 1'b0;
      #1;
      check("rst_async", {26'd0, pc3, ifid3, bub3, fl3, frz3, st3}, {26'd0, NORM});
`ifdef HAZARD_PERF_EN
      check("perf_sc3_rst", sc3, 32'd0);
      check("perf_fc3_rst", fc3, 32'd0);
      check("perf_sc1_rst", sc1, 32'd0);
      check("perf_fc1_rst", fc1, 32'd0);
`endif
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc3(idle, NORM,  "post_c0");
      cyc3(haz,  STALL, "post_c1");
      cyc3(idle, STALL, "post_c2");
      cyc3(idle, STALL, "post_c3");
      cyc3(idle, NORM,  "post_c4");
      cyc3(br,   FLUSH, "post_c5");
      cyc3(idle, NORM,  "post_c6");
`ifdef HAZARD_PERF_EN
      check("perf_sc3", sc3, 32'd3);
      check("perf_fc3", fc3, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
